// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter, MSB first, with a ready/valid load
// handshake and gapless streaming of back-to-back words.
module piso_serializer #(
    parameter int   WIDTH      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             OUT,
    output logic             OUT_VALID,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_bit, accept;

    always_comb begin
        last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        accept   = LOAD_VALID && ((state_q == IDLE) || last_bit);
        state_d  = accept ? SHIFT : (last_bit ? IDLE : state_q);
        sr_d     = accept ? DATA_IN : ((state_q == SHIFT) ? {sr_q[WIDTH-2:0], 1'b0} : sr_q);
        cnt_d    = (accept || last_bit) ? '0 : ((state_q == SHIFT) ? cnt_q + CW'(1) : cnt_q);
        done_d   = last_bit;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs come purely from registers so nothing on the inputs reaches them in the same cycle.
    assign LOAD_READY = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_CNT));
    assign OUT        = (state_q == SHIFT) ? sr_q[WIDTH-1] : IDLE_LEVEL;
    assign OUT_VALID  = (state_q == SHIFT);
    assign DONE       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and random checks of piso_serializer against a
// bit-queue reference model plus a serial loopback receiver.
module tb_piso_serializer;
    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RESET, LOAD_VALID;
    logic [W-1:0] DATA_IN;
    logic         LOAD_READY, OUT, OUT_VALID, DONE;
    logic [W-1:0] rx = '0;

    int checks = 0;
    int failures = 0;

    logic         bit_q[$];
    logic         last_q[$];
    logic [W-1:0] word_q[$];
    logic         exp_done = 1'b0;
    int           accepted = 0;

    piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(LOAD_READY), .OUT(OUT), .OUT_VALID(OUT_VALID), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (OUT_VALID) rx <= {rx[W-2:0], OUT};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model: a queue holds every bit still owed on the line.
    task automatic step();
        logic         acc;
        logic [W-1:0] d;
        acc = LOAD_VALID && (bit_q.size() <= 1);
        d   = DATA_IN;
        @(posedge CLK);
        exp_done = 1'b0;
        if (RESET) begin
            bit_q.delete();
            last_q.delete();
            word_q.delete();
        end else begin
            if (bit_q.size() > 0) begin
                exp_done = last_q[0];
                void'(bit_q.pop_front());
                void'(last_q.pop_front());
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) begin
                    bit_q.push_back(d[i]);
                    last_q.push_back(i == 0);
                end
                word_q.push_back(d);
                accepted++;
            end
        end
        #1;
        chk("out", {31'd0, OUT}, {31'd0, (bit_q.size() > 0) ? bit_q[0] : 1'b0});
        chk("out_valid", {31'd0, OUT_VALID}, {31'd0, bit_q.size() > 0});
        chk("load_ready", {31'd0, LOAD_READY}, {31'd0, bit_q.size() <= 1});
        chk("done", {31'd0, DONE}, {31'd0, exp_done});
        if (exp_done && word_q.size() > 0) chk("loopback", {16'd0, rx}, {16'd0, word_q.pop_front()});
    endtask

    initial begin
        int cyc;
        RESET = 1'b1;
        LOAD_VALID = 1'b1;
        DATA_IN = 16'hBEEF;
        step();
        step();
        RESET = 1'b0;
        LOAD_VALID = 1'b0;
        step();
        chk("reset_no_accept", accepted, 0);
        // Single word with a literal expected bit pattern.
        LOAD_VALID = 1'b1;
        DATA_IN = 16'hA5C3;
        step();
        LOAD_VALID = 1'b0;
        DATA_IN = 16'h0000;
        for (int i = 0; i < W + 2; i++) step();
        chk("single_rx", {16'd0, rx}, 32'h0000A5C3);
        // Back-to-back words.
        LOAD_VALID = 1'b1;
        DATA_IN = 16'hFFFF;
        step();
        DATA_IN = 16'h0001;
        for (int i = 0; i < W; i++) step();
        LOAD_VALID = 1'b0;
        for (int i = 0; i < W + 2; i++) step();
        chk("b2b_accepted", accepted, 3);
        // Load offered during bit 5 must be ignored.
        LOAD_VALID = 1'b1;
        DATA_IN = 16'hFFFF;
        step();
        LOAD_VALID = 1'b0;
        for (int i = 0; i < 5; i++) step();
        LOAD_VALID = 1'b1;
        DATA_IN = 16'h0000;
        step();
        LOAD_VALID = 1'b0;
        for (int i = 0; i < W; i++) step();
        chk("ignored_accepted", accepted, 4);
        // Reset during bit 7 aborts the word.
        LOAD_VALID = 1'b1;
        DATA_IN = 16'h1234;
        step();
        LOAD_VALID = 1'b0;
        for (int i = 0; i < 7; i++) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        chk("abort_idle", {31'd0, OUT_VALID}, 32'd0);
        LOAD_VALID = 1'b1;
        DATA_IN = 16'h8000;
        step();
        LOAD_VALID = 1'b0;
        for (int i = 0; i < W + 2; i++) step();
        chk("after_abort_rx", {16'd0, rx}, 32'h00008000);
        // Random traffic until 100 more words have gone through.
        cyc = 0;
        while (accepted < 106 && cyc < 20000) begin
            LOAD_VALID = ($urandom_range(0, 9) < 7);
            DATA_IN = W'($urandom);
            step();
            cyc++;
        end
        chk("random_words_accepted", {31'd0, accepted >= 106}, 32'd1);
        LOAD_VALID = 1'b0;
        for (int i = 0; i < W + 3; i++) step();
        chk("drained", word_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
